// File: rtl/addern_seq.sv
// addern_seq: multi-cycle N-bit adder/subtractor processing K bits per clock
module addern_seq #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic         cin_i,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] s_o,
  output logic         cout_o,
  output logic         overflow_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int C  = N / K;
  localparam int CW = C > 1 ? $clog2(C) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K:0]    csum;
  logic          last;
  assign csum = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
  assign last = cnt_q == CW'(C - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start_i) begin
      state_d = RUN;
      a_d     = x_i;
      b_d     = sub_i ? ~y_i : y_i;
      carry_d = sub_i | cin_i;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      // operands shift down so the active chunk is always at bit 0; sum bits enter from the top
      a_d     = a_q >> K;
      b_d     = b_q >> K;
      acc_d   = N'({csum[K-1:0], acc_q} >> K);
      carry_d = csum[K];
      cnt_d   = last ? cnt_q : cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        s_d     = acc_d;
        cout_d  = csum[K];
        ovf_d   = csum[K] ^ csum[K-1] ^ a_q[K-1] ^ b_q[K-1];
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign s_o        = s_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
  assign busy_o     = state_q == RUN;
  assign done_o     = state_q == DONE;
endmodule

// File: tb/tb_addern_seq.sv
// tb_addern_seq: directed and reference-model checks of addern_seq at N16/K4, N8/K8, N32/K1
module tb_addern_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  int cmp = 0;
  int bad = 0;
  int bc, lat, nd, both, mv;

  logic        start16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] x16 = 0, y16 = 0, s16;
  logic        cout16, ovf16, busy16, done16;
  logic        start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0]  x8 = 0, y8 = 0, s8;
  logic        cout8, ovf8, busy8, done8;
  logic        start32 = 0, sub32 = 0, cin32 = 0;
  logic [31:0] x32 = 0, y32 = 0, s32;
  logic        cout32, ovf32, busy32, done32;

  addern_seq #(.N(16), .K(4)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .sub_i(sub16), .cin_i(cin16),
    .x_i(x16), .y_i(y16), .s_o(s16), .cout_o(cout16), .overflow_o(ovf16),
    .busy_o(busy16), .done_o(done16));
  addern_seq #(.N(8), .K(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .sub_i(sub8), .cin_i(cin8),
    .x_i(x8), .y_i(y8), .s_o(s8), .cout_o(cout8), .overflow_o(ovf8),
    .busy_o(busy8), .done_o(done8));
  addern_seq #(.N(32), .K(1)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .sub_i(sub32), .cin_i(cin32),
    .x_i(x32), .y_i(y32), .s_o(s32), .cout_o(cout32), .overflow_o(ovf32),
    .busy_o(busy32), .done_o(done32));

  task automatic pulse16(input logic sb, input logic c, input logic [15:0] xx, input logic [15:0] yy);
    @(negedge clk);
    start16 = 1; sub16 = sb; cin16 = c; x16 = xx; y16 = yy;
    @(negedge clk);
    start16 = 0;
  endtask

  // samples one negedge per cycle, starting in the first RUN cycle
  task automatic observe16(input int w);
    logic [15:0] s0;
    bc = 0; lat = 0; nd = 0; both = 0; mv = 0; s0 = s16;
    for (int i = 1; i <= w; i++) begin
      if (busy16) begin bc++; if (s16 !== s0) mv++; end
      if (done16) begin nd++; if (lat == 0) lat = i; end
      if (busy16 && done16) both++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1;
    cmp++; if ({s16, cout16, ovf16, busy16, done16} !== 20'h0) begin bad++; $display("FAIL reset16: got %h required 0", {s16, cout16, ovf16, busy16, done16}); end
    cmp++; if ({s8, cout8, ovf8, busy8, done8} !== 12'h0) begin bad++; $display("FAIL reset8: got %h required 0", {s8, cout8, ovf8, busy8, done8}); end
    cmp++; if ({s32, cout32, ovf32, busy32, done32} !== 36'h0) begin bad++; $display("FAIL reset32: got %h required 0", {s32, cout32, ovf32, busy32, done32}); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_add_overflow;
    pulse16(0, 0, 16'h7FFF, 16'h0001);
    observe16(10);
    cmp++; if (s16 !== 16'h8000) begin bad++; $display("FAIL add_ovf_s: got %h required 8000", s16); end
    cmp++; if ({cout16, ovf16} !== 2'b01) begin bad++; $display("FAIL add_ovf_flags: got %b required 01", {cout16, ovf16}); end
    cmp++; if (bc !== 4) begin bad++; $display("FAIL add_ovf_busy: got %0d required 4", bc); end
    cmp++; if (lat !== 5) begin bad++; $display("FAIL add_ovf_latency: got %0d required 5", lat); end
    cmp++; if (nd !== 1 || both !== 0) begin bad++; $display("FAIL add_ovf_done: pulses %0d overlap %0d required 1/0", nd, both); end
  endtask

  task automatic test_add_carry;
    pulse16(0, 1, 16'hFFFF, 16'h0001);
    observe16(10);
    cmp++; if (mv !== 0) begin bad++; $display("FAIL hold_during_run: s changed %0d times required 0", mv); end
    cmp++; if (s16 !== 16'h0001) begin bad++; $display("FAIL add_carry_s: got %h required 0001", s16); end
    cmp++; if ({cout16, ovf16} !== 2'b10) begin bad++; $display("FAIL add_carry_flags: got %b required 10", {cout16, ovf16}); end
  endtask

  task automatic test_sub;
    pulse16(1, 0, 16'h0005, 16'h0007);
    observe16(10);
    cmp++; if (s16 !== 16'hFFFE) begin bad++; $display("FAIL sub_neg_s: got %h required fffe", s16); end
    cmp++; if ({cout16, ovf16} !== 2'b00) begin bad++; $display("FAIL sub_neg_flags: got %b required 00", {cout16, ovf16}); end
    pulse16(1, 0, 16'h8000, 16'h0001);
    observe16(10);
    cmp++; if (s16 !== 16'h7FFF) begin bad++; $display("FAIL sub_ovf_s: got %h required 7fff", s16); end
    cmp++; if ({cout16, ovf16} !== 2'b11) begin bad++; $display("FAIL sub_ovf_flags: got %b required 11", {cout16, ovf16}); end
    cmp++; if (lat !== 5) begin bad++; $display("FAIL sub_latency: got %0d required 5", lat); end
  endtask

  task automatic test_start_ignored;
    pulse16(0, 0, 16'h1234, 16'h1111);
    start16 = 1; sub16 = 1; cin16 = 1; x16 = 16'hFFFF; y16 = 16'hFFFF;
    @(negedge clk);
    start16 = 0;
    observe16(10);
    cmp++; if (s16 !== 16'h2345) begin bad++; $display("FAIL ignore_s: got %h required 2345", s16); end
    cmp++; if ({cout16, ovf16} !== 2'b00) begin bad++; $display("FAIL ignore_flags: got %b required 00", {cout16, ovf16}); end
    cmp++; if (nd !== 1 || lat !== 4) begin bad++; $display("FAIL ignore_done: pulses %0d at %0d required 1 at 4", nd, lat); end
    cmp++; if ({busy16, done16} !== 2'b00) begin bad++; $display("FAIL ignore_idle: got %b required 00", {busy16, done16}); end
  endtask

  task automatic test_reset_mid_run;
    pulse16(0, 0, 16'h0100, 16'h0200);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    cmp++; if ({s16, cout16, ovf16, busy16, done16} !== 20'h0) begin bad++; $display("FAIL reset_mid_run: got %h required 0", {s16, cout16, ovf16, busy16, done16}); end
    @(negedge clk);
    rst_n = 1;
    observe16(8);
    cmp++; if (nd !== 0 || bc !== 0) begin bad++; $display("FAIL reset_abort: done %0d busy %0d required 0/0", nd, bc); end
    @(negedge clk);
    rst_n = 0;
    #1;
    start16 = 1; sub16 = 0; cin16 = 1; x16 = 16'h1000; y16 = 16'h0234;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start16 = 0;
    observe16(10);
    cmp++; if (s16 !== 16'h1235 || lat !== 5) begin bad++; $display("FAIL after_reset: s %h lat %0d required 1235 lat 5", s16, lat); end
  endtask

  task automatic test_n8;
    logic [8:0] r;
    logic [7:0] yb;
    logic       eo;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start8 = 1;
      if (k == 0) begin x8 = 8'h7F; y8 = 8'h01; sub8 = 0; cin8 = 0; end
      else begin x8 = 8'($urandom); y8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom); end
      yb = sub8 ? ~y8 : y8;
      r  = {1'b0, x8} + {1'b0, yb} + {8'h0, sub8 | cin8};
      eo = (x8[7] == yb[7]) && (r[7] != x8[7]);
      @(negedge clk);
      start8 = 0;
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
        if (done8 && lat == 0) lat = i;
        @(negedge clk);
      end
      cmp++; if ({cout8, s8} !== r) begin bad++; $display("FAIL n8_sum[%0d]: got %h required %h", k, {cout8, s8}, r); end
      cmp++; if (ovf8 !== eo) begin bad++; $display("FAIL n8_ovf[%0d]: got %b required %b", k, ovf8, eo); end
      cmp++; if (lat !== 2) begin bad++; $display("FAIL n8_latency[%0d]: got %0d required 2", k, lat); end
    end
  endtask

  task automatic test_n32;
    logic [32:0] r;
    logic [31:0] yb;
    logic        eo;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start32 = 1;
      if (k == 0) begin x32 = 32'h8000_0000; y32 = 32'h0000_0001; sub32 = 1; cin32 = 0; end
      else begin x32 = $urandom; y32 = $urandom; sub32 = 1'($urandom); cin32 = 1'($urandom); end
      yb = sub32 ? ~y32 : y32;
      r  = {1'b0, x32} + {1'b0, yb} + {32'h0, sub32 | cin32};
      eo = (x32[31] == yb[31]) && (r[31] != x32[31]);
      @(negedge clk);
      start32 = 0;
      lat = 0;
      for (int i = 1; i <= 36; i++) begin
        if (done32 && lat == 0) lat = i;
        @(negedge clk);
      end
      cmp++; if ({cout32, s32} !== r) begin bad++; $display("FAIL n32_sum[%0d]: got %h required %h", k, {cout32, s32}, r); end
      cmp++; if (ovf32 !== eo) begin bad++; $display("FAIL n32_ovf[%0d]: got %b required %b", k, ovf32, eo); end
      cmp++; if (lat !== 33) begin bad++; $display("FAIL n32_latency[%0d]: got %0d required 33", k, lat); end
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_add_carry;
    test_sub;
    test_start_ignored;
    test_reset_mid_run;
    test_n8;
    test_n32;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
